// File: rtl/beat_sequencer_pkg.sv
// Shared definitions for the beat sequencer: FSM state encoding and parameter defaults.
package beat_sequencer_pkg;

    // Encoding is visible on the state port, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAYING   = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    localparam int DEF_FRAMES_PER_BEAT = 30;  // 60 frame ticks/s -> 120 BPM
    localparam int DEF_COUNTDOWN_BEATS = 3;
    localparam int DEF_SONG_BEATS      = 128;
    localparam int DEF_BEAT_W          = 8;

    // States in which frame ticks advance the musical counters.
    function automatic logic is_counting(input state_e s);
        return (s == ST_COUNTDOWN) || (s == ST_PLAYING);
    endfunction

endpackage

// File: rtl/beat_sequencer_if.sv
// Control/status bundle between the game logic and the beat sequencer.
interface beat_sequencer_if
    import beat_sequencer_pkg::*;
#(
    parameter int FRAMES_PER_BEAT = DEF_FRAMES_PER_BEAT,
    parameter int BEAT_W          = DEF_BEAT_W
);
    localparam int FRAME_W = $clog2(FRAMES_PER_BEAT);

    // controls
    logic               start;
    logic               pause;
    logic               stop;
    // timebase / status
    logic               frame_tick;
    logic               beat_tick;
    logic [BEAT_W-1:0]  beat_idx;
    logic [FRAME_W-1:0] frame_in_beat;
    logic [1:0]         countdown;
    logic [2:0]         state;
    logic               playing;
    logic               song_done;

    modport master (
        output start, pause, stop,
        input  frame_tick, beat_tick, beat_idx, frame_in_beat,
               countdown, state, playing, song_done
    );

    modport slave (
        input  start, pause, stop,
        output frame_tick, beat_tick, beat_idx, frame_in_beat,
               countdown, state, playing, song_done
    );

endinterface

// File: rtl/beat_sequencer_frame_edge_sync.sv
// Brings the slow toggling frame clock into the clk domain and emits one
// pulse per edge (rising and falling). Pulses are suppressed until the arm
// counter has run for 3 cycles after reset, so a chain that refills from
// reset with a high input does not fake an edge.
module frame_edge_sync
    import beat_sequencer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic edge_pulse
);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       s3_q, s3_d;
    logic [1:0] arm_cnt_q, arm_cnt_d;
    logic       armed_q, armed_d;
    logic       edge_pulse_q, edge_pulse_d;

    // Sync chain shift, arm count and registered edge pulse.
    always_comb begin
        s1_d         = async_in;
        s2_d         = s1_q;
        s3_d         = s2_q;
        arm_cnt_d    = arm_cnt_q;
        if (!armed_q && arm_cnt_q != 2'd2)
            arm_cnt_d = arm_cnt_q + 2'd1;
        armed_d      = armed_q | (arm_cnt_q == 2'd2);
        edge_pulse_d = (s2_q ^ s3_q) & armed_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            arm_cnt_q    <= 2'd0;
            armed_q      <= 1'b0;
            edge_pulse_q <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            arm_cnt_q    <= arm_cnt_d;
            armed_q      <= armed_d;
            edge_pulse_q <= edge_pulse_d;
        end
    end

    assign edge_pulse = edge_pulse_q;

endmodule

// File: rtl/beat_sequencer.sv
// Musical timebase: counts frame ticks into beats and sequences one song
// through count-in, play, pause and done. All counters are frozen while
// paused, and the frozen values stay visible on the outputs.
module beat_sequencer
    import beat_sequencer_pkg::*;
#(
    parameter int FRAMES_PER_BEAT = DEF_FRAMES_PER_BEAT,
    parameter int COUNTDOWN_BEATS = DEF_COUNTDOWN_BEATS,
    parameter int SONG_BEATS      = DEF_SONG_BEATS,
    parameter int BEAT_W          = DEF_BEAT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_clk_in,
    beat_sequencer_if.slave  bus
);

    localparam int FRAME_W = $clog2(FRAMES_PER_BEAT);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_BEAT - 1);
    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(SONG_BEATS - 1);
    localparam logic [1:0]         CD_INIT    = 2'(COUNTDOWN_BEATS);

    logic frame_tick;

    state_e             state_q, state_d;
    state_e             ret_q, ret_d;        // where PAUSED resumes to
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [1:0]         cd_q, cd_d;
    logic               beat_tick_q, beat_tick_d;
    logic               start_ok_q, start_ok_d;  // start seen low since last accepted start
    logic               playing, song_done;

    frame_edge_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (frame_clk_in),
        .edge_pulse (frame_tick)
    );

    // State register: FSM state plus the counters it owns.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ret_q       <= ST_IDLE;
            frame_q     <= '0;
            beat_q      <= '0;
            cd_q        <= 2'd0;
            beat_tick_q <= 1'b0;
            start_ok_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            frame_q     <= frame_d;
            beat_q      <= beat_d;
            cd_q        <= cd_d;
            beat_tick_q <= beat_tick_d;
            start_ok_q  <= start_ok_d;
        end
    end

    // Next state and counters; priority stop > pause > start > frame tick.
    // A tick arriving with a stop/pause/start is simply dropped.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        frame_d     = frame_q;
        beat_d      = beat_q;
        cd_d        = cd_q;
        beat_tick_d = 1'b0;
        // DONE only restarts on a fresh start, so a held start cannot loop songs.
        start_ok_d  = start_ok_q | ~bus.start;

        if (bus.stop) begin
            state_d = ST_IDLE;
            frame_d = '0;
            beat_d  = '0;
            cd_d    = 2'd0;
        end else if (bus.pause && is_counting(state_q)) begin
            ret_d   = state_q;
            state_d = ST_PAUSED;
        end else if ((bus.pause || bus.start) && state_q == ST_PAUSED) begin
            state_d = ret_q;
        end else if (bus.start &&
                     (state_q == ST_IDLE || (state_q == ST_DONE && start_ok_q))) begin
            state_d    = ST_COUNTDOWN;
            cd_d       = CD_INIT;
            frame_d    = '0;
            beat_d     = '0;
            start_ok_d = 1'b0;
        end else if (frame_tick && is_counting(state_q)) begin
            if (frame_q == FRAME_LAST) begin
                frame_d     = '0;
                beat_tick_d = 1'b1;
                if (state_q == ST_COUNTDOWN) begin
                    if (cd_q == 2'd1) begin
                        state_d = ST_PLAYING;
                        cd_d    = 2'd0;
                        beat_d  = '0;
                    end else begin
                        cd_d = cd_q - 2'd1;
                    end
                end else if (beat_q == BEAT_LAST) begin
                    state_d = ST_DONE;   // beat_idx holds on the last beat
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        playing   = (state_q == ST_PLAYING);
        song_done = (state_q == ST_DONE);
    end

    assign bus.frame_tick    = frame_tick;
    assign bus.beat_tick     = beat_tick_q;
    assign bus.beat_idx      = beat_q;
    assign bus.frame_in_beat = frame_q;
    assign bus.countdown     = cd_q;
    assign bus.state         = state_q;
    assign bus.playing       = playing;
    assign bus.song_done     = song_done;

endmodule
